// File: rtl/mm_tile_scheduler_if.sv
// Command, A/B instruction and tile-completion signals of the matrix-multiply tile scheduler.
// The master modport is the scheduler side. The slave modport is the environment side.
interface mm_tile_scheduler_if #(
    parameter int N                   = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int COUNTER_BITS        = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int TILE_BITS           = $clog2(MAX_MATRIX_LENGTH / N + 1)
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [MEMORY_ADDRESS_BITS-1:0] cmd_a_base;
    logic [MEMORY_ADDRESS_BITS-1:0] cmd_b_base;
    logic [COUNTER_BITS-1:0]        cmd_k_len;
    logic [TILE_BITS-1:0]           cmd_row_tiles;
    logic [TILE_BITS-1:0]           cmd_col_tiles;

    logic                           a_instr_valid;
    logic                           a_instr_ready;
    logic [MEMORY_ADDRESS_BITS-1:0] a_address;
    logic [COUNTER_BITS-1:0]        a_length;
    logic [TILE_BITS-1:0]           a_repeats;

    logic                           b_instr_valid;
    logic                           b_instr_ready;
    logic [MEMORY_ADDRESS_BITS-1:0] b_address;
    logic [COUNTER_BITS-1:0]        b_length;
    logic [TILE_BITS-1:0]           b_repeats;

    logic                           tile_done;
    logic                           busy;
    logic                           cmd_done;

    modport master (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_k_len, cmd_row_tiles, cmd_col_tiles,
        input  a_instr_ready, b_instr_ready, tile_done,
        output cmd_ready, a_instr_valid, a_address, a_length, a_repeats,
        output b_instr_valid, b_address, b_length, b_repeats, busy, cmd_done
    );

    modport slave (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_k_len, cmd_row_tiles, cmd_col_tiles,
        output a_instr_ready, b_instr_ready, tile_done,
        input  cmd_ready, a_instr_valid, a_address, a_length, a_repeats,
        input  b_instr_valid, b_address, b_length, b_repeats, busy, cmd_done
    );
endinterface

// File: rtl/mm_tile_scheduler.sv
// Sequences one C = A x B over N x N output tiles: one A row-block per row tile, one B block per tile.
// Optional performance counters are enabled by defining TILE_SCHED_PERF_EN.
module mm_tile_scheduler #(
    parameter int N                   = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int COUNTER_BITS        = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int TILE_BITS           = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    mm_tile_scheduler_if.master        bus
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                issue_cycles
`endif
);
    localparam int                           DONE_BITS = 2 * TILE_BITS;
    localparam logic [MEMORY_ADDRESS_BITS-1:0] ADDR_N  = MEMORY_ADDRESS_BITS'(N);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_A = 3'd1,
        S_ISSUE_B = 3'd2,
        S_DRAIN   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [MEMORY_ADDRESS_BITS-1:0] r_a_ptr;
    logic [MEMORY_ADDRESS_BITS-1:0] r_b_ptr;
    logic [MEMORY_ADDRESS_BITS-1:0] r_b_base;
    logic [MEMORY_ADDRESS_BITS-1:0] r_stride;
    logic [COUNTER_BITS-1:0]        r_k_len;
    logic [TILE_BITS-1:0]           r_row_tiles;
    logic [TILE_BITS-1:0]           r_col_tiles;
    logic [TILE_BITS-1:0]           r_row_idx;
    logic [TILE_BITS-1:0]           r_col_idx;
    logic [DONE_BITS-1:0]           r_done_cnt;
    logic [DONE_BITS-1:0]           r_total;

    logic w_accept;
    logic w_degenerate;
    logic w_a_xfer;
    logic w_b_xfer;
    logic w_last_col;
    logic w_last_row;

    assign w_accept     = bus.cmd_valid && (r_state == S_IDLE);
    assign w_degenerate = (bus.cmd_k_len == COUNTER_BITS'(0)) || (bus.cmd_row_tiles == TILE_BITS'(0))
                          || (bus.cmd_col_tiles == TILE_BITS'(0));
    assign w_a_xfer     = (r_state == S_ISSUE_A) && bus.a_instr_ready;
    assign w_b_xfer     = (r_state == S_ISSUE_B) && bus.b_instr_ready;
    assign w_last_col   = (r_col_idx == r_col_tiles - TILE_BITS'(1));
    assign w_last_row   = (r_row_idx == r_row_tiles - TILE_BITS'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_degenerate ? S_FINISH : S_ISSUE_A;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE_A: begin
                if (w_a_xfer) begin
                    w_next_state = S_ISSUE_B;
                end else begin
                    w_next_state = S_ISSUE_A;
                end
            end
            S_ISSUE_B: begin
                if (w_b_xfer && w_last_col) begin
                    w_next_state = w_last_row ? S_DRAIN : S_ISSUE_A;
                end else begin
                    w_next_state = S_ISSUE_B;
                end
            end
            S_DRAIN: begin
                if (r_done_cnt == r_total) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only, so valids never follow ready
    always_comb begin
        bus.cmd_ready     = 1'b0;
        bus.busy          = 1'b1;
        bus.a_instr_valid = 1'b0;
        bus.b_instr_valid = 1'b0;
        bus.cmd_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_ISSUE_A: bus.a_instr_valid = 1'b1;
            S_ISSUE_B: bus.b_instr_valid = 1'b1;
            S_DRAIN:   bus.busy          = 1'b1;
            S_FINISH:  bus.cmd_done      = 1'b1;
            default:   bus.busy          = 1'b1;
        endcase
    end

    assign bus.a_address = r_a_ptr;
    assign bus.a_length  = r_k_len;
    assign bus.a_repeats = r_col_tiles;
    assign bus.b_address = r_b_ptr;
    assign bus.b_length  = r_k_len;
    assign bus.b_repeats = TILE_BITS'(1);

    // Command latch and address/tile-index walk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_ptr     <= MEMORY_ADDRESS_BITS'(0);
            r_b_ptr     <= MEMORY_ADDRESS_BITS'(0);
            r_b_base    <= MEMORY_ADDRESS_BITS'(0);
            r_stride    <= MEMORY_ADDRESS_BITS'(0);
            r_k_len     <= COUNTER_BITS'(0);
            r_row_tiles <= TILE_BITS'(0);
            r_col_tiles <= TILE_BITS'(0);
            r_row_idx   <= TILE_BITS'(0);
            r_col_idx   <= TILE_BITS'(0);
            r_total     <= DONE_BITS'(0);
        end else if (w_accept) begin
            r_a_ptr     <= bus.cmd_a_base;
            r_b_ptr     <= bus.cmd_b_base;
            r_b_base    <= bus.cmd_b_base;
            r_stride    <= ADDR_N * MEMORY_ADDRESS_BITS'(bus.cmd_k_len);
            r_k_len     <= bus.cmd_k_len;
            r_row_tiles <= bus.cmd_row_tiles;
            r_col_tiles <= bus.cmd_col_tiles;
            r_row_idx   <= TILE_BITS'(0);
            r_col_idx   <= TILE_BITS'(0);
            r_total     <= DONE_BITS'(bus.cmd_row_tiles) * DONE_BITS'(bus.cmd_col_tiles);
        end else if (w_a_xfer) begin
            r_a_ptr   <= r_a_ptr + r_stride;
            r_b_ptr   <= r_b_base;
            r_col_idx <= TILE_BITS'(0);
        end else if (w_b_xfer) begin
            r_b_ptr   <= r_b_ptr + r_stride;
            r_col_idx <= r_col_idx + TILE_BITS'(1);
            if (w_last_col && !w_last_row) begin
                r_row_idx <= r_row_idx + TILE_BITS'(1);
            end
        end
    end

    // Tile completions count in every non-idle state; accept restarts the count
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_done_cnt <= DONE_BITS'(0);
        end else if ((r_state != S_IDLE) && bus.tile_done) begin
            r_done_cnt <= r_done_cnt + DONE_BITS'(1);
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic w_stall;
    assign w_stall = ((r_state == S_ISSUE_A) && !bus.a_instr_ready)
                     || ((r_state == S_ISSUE_B) && !bus.b_instr_ready);

    // Saturating stall and activity counters
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            stall_cycles <= 32'd0;
            issue_cycles <= 32'd0;
        end else begin
            if (w_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((r_state != S_IDLE) && (issue_cycles != 32'hFFFF_FFFF)) begin
                issue_cycles <= issue_cycles + 32'd1;
            end
        end
    end
`endif
endmodule
